// File: rtl/econ_arb_pkg.sv
// Shared types, constants and the round-robin search used by econ_arbiter.
// Optional feature macro used by the top level: ECON_ARB_STATS_EN.
package econ_arb_pkg;

  localparam int IN_W    = 864;
  localparam int OUT_W   = 54;
  localparam int MAX_REQ = 8;

  typedef logic [2:0] tag_t;

  // First set bit of vld at or after ptr, wrapping within nreq entries.
  // Returns ptr unchanged when nothing is requesting.
  function automatic tag_t rr_pick(input logic [MAX_REQ-1:0] vld, input tag_t ptr,
                                   input int nreq);
    tag_t pick;
    tag_t idx;
    logic found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = tag_t'((int'(ptr) + i) % nreq);
      if ((i < nreq) && !found && vld[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/econ_tag_fifo.sv
// In-order FIFO of requester tags with registered full/empty flags.
// Pushes while full and pops while empty are ignored.
module econ_tag_fifo
  import econ_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  tag_t                     wdata_i,
  input  logic                     pop_i,
  output tag_t                     rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  tag_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  // Pointer/count update; flags are computed from the next count and registered.
  always_comb begin
    do_push  = push_i & ~full_q;
    do_pop   = pop_i & ~empty_q;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
  end

  // Control state; reset discards every held tag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Tag storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/econ_arbiter.sv
// Round-robin front end sharing one econV0 core among NREQ requesters.
// Handshake: a transfer happens on any cycle where valid and ready are both
// high; valid must not depend on ready. Results return in issue order and are
// steered by the tag at the FIFO head.
// Optional macro ECON_ARB_STATS_EN adds per-requester result counters (stat_cnt).
module econ_arbiter
  import econ_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int IN_W  = econ_arb_pkg::IN_W,
  parameter int OUT_W = econ_arb_pkg::OUT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ*IN_W-1:0]     req_dat,
  input  logic [NREQ-1:0]          req_vld,
  output logic [NREQ-1:0]          req_rdy,
  output logic [OUT_W-1:0]         rsp_dat,
  output logic [NREQ-1:0]          rsp_vld,
  input  logic [NREQ-1:0]          rsp_rdy,
  output logic [IN_W-1:0]          core_in_dat,
  output logic                     core_in_vld,
  input  logic                     core_in_rdy,
  input  logic [OUT_W-1:0]         core_out_dat,
  input  logic                     core_out_vld,
  output logic                     core_out_rdy,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     proto_err
`ifdef ECON_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]       stat_cnt
`endif
);

  tag_t                 ptr_q, ptr_d;
  tag_t                 grant;
  tag_t                 head;
  logic [MAX_REQ-1:0]   vld_ext;
  logic                 any_vld;
  logic                 fifo_full, fifo_empty;
  logic                 accept, pop;
  logic                 proto_err_q, proto_err_d;

  // Arbitration and input steering. Outputs are also held low while rst is
  // asserted so nothing is offered to a core that is itself in reset.
  always_comb begin
    vld_ext             = '0;
    vld_ext[NREQ-1:0]   = req_vld;
    any_vld             = |req_vld;
    grant               = rr_pick(vld_ext, ptr_q, NREQ);
    core_in_vld         = any_vld & ~fifo_full & rst;
    core_in_dat         = '0;
    req_rdy             = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == tag_t'(i)) begin
        core_in_dat = req_dat[i*IN_W +: IN_W];
        req_rdy[i]  = core_in_rdy & ~fifo_full & any_vld & rst;
      end
    end
    accept = core_in_vld & core_in_rdy;
    ptr_d  = ptr_q;
    if (accept) ptr_d = (grant == tag_t'(NREQ - 1)) ? '0 : grant + tag_t'(1);
  end

  // Result steering to the requester at the FIFO head; protocol error latch.
  always_comb begin
    rsp_vld      = '0;
    core_out_rdy = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (head == tag_t'(i)) begin
        rsp_vld[i]   = core_out_vld & ~fifo_empty;
        core_out_rdy = ~fifo_empty & rsp_rdy[i];
      end
    end
    pop         = core_out_vld & core_out_rdy;
    proto_err_d = proto_err_q | (core_out_vld & fifo_empty);
  end

  // Round-robin pointer and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      proto_err_q <= proto_err_d;
    end
  end

  econ_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (accept),
    .wdata_i (grant),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (inflight),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rsp_dat   = core_out_dat;
  assign proto_err = proto_err_q;

`ifdef ECON_ARB_STATS_EN
  logic [NREQ-1:0][15:0] stat_q;

  // Count completed result handshakes per requester, wrapping at 2^16.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (pop && (head == tag_t'(i))) stat_q[i] <= stat_q[i] + 16'd1;
      end
    end
  end

  assign stat_cnt = stat_q;
`endif

endmodule

// File: doc/econ_arbiter.md
# econ_arbiter

Round-robin arbiter that shares one econV0 encoder core among NREQ requesters, each presenting 864-bit input samples on a valid/ready handshake. Accepted samples are tagged with the requester index in an in-order tag FIFO. Each 54-bit core result is steered back to the requester that issued it. Sits between the per-module data sources and the single econV0 instance.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DEPTH, 8, tag FIFO depth; also the maximum number of samples in flight inside the core (power of 2)
- IN_W, 864, core input width
- OUT_W, 54, core output width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_dat  in  NREQ*IN_W  requester i occupies bits [i*IN_W +: IN_W]
- req_vld  in  NREQ  per-requester valid
- req_rdy  out  NREQ  per-requester ready
- rsp_dat  out  OUT_W  result bus shared by all requesters
- rsp_vld  out  NREQ  one-hot result valid
- rsp_rdy  in  NREQ  per-requester result ready
- core_in_dat  out  IN_W  to econV0 input_48_rsc_dat
- core_in_vld  out  1  to input_48_rsc_vld
- core_in_rdy  in  1  from input_48_rsc_rdy
- core_out_dat  in  OUT_W  from layer7_out_rsc_dat
- core_out_vld  in  1  from layer7_out_rsc_vld
- core_out_rdy  out  1  to layer7_out_rsc_rdy
- inflight  out  $clog2(DEPTH)+1  number of tags currently held
- proto_err  out  1  sticky; set when a core result arrives while no tag is held

## Operation
- Round-robin pointer `ptr` (0..NREQ-1). `grant` is the first i with req_vld[i]=1, searching from ptr upward with wrap-around. Grant is combinational.
- Input path:
  - core_in_vld = |req_vld & !full.
  - core_in_dat = req_dat of the granted requester.
  - req_rdy[grant] = core_in_rdy & !full; all other req_rdy bits are 0.
- Accept: core_in_vld & core_in_rdy. On accept, push grant into the tag FIFO and set ptr = (grant+1) mod NREQ. With no accept, ptr holds.
- Output path, with head = FIFO head tag:
  - rsp_vld[head] = core_out_vld & !empty.
  - core_out_rdy = !empty & rsp_rdy[head].
  - rsp_dat = core_out_dat.
- Pop the FIFO on core_out_vld & core_out_rdy.
- Push and pop in the same cycle are both allowed:
  - When empty, only the push takes effect on the count; the pop cannot occur because core_out_rdy=0.
  - When full, the push is blocked even if a pop happens in the same cycle. The input path depends only on the registered `full`.
- Error case: core_out_vld=1 while empty sets proto_err. The result is not accepted. proto_err clears only on reset.
- Requesters must hold req_dat and req_vld stable until req_rdy is seen; the arbiter does not re-check this.

## Timing
- Arbitration and response steering are combinational: 0 added cycles on either path.
- End-to-end latency equals the econV0 latency.
- Reset values: ptr=0; FIFO empty; inflight=0; proto_err=0.
  - Consequently req_rdy=0, core_in_vld=0, rsp_vld=0, core_out_rdy=0.
- Throughput: one accept per cycle, as long as the core accepts and fewer than DEPTH tags are held.
- `full` and `empty` are registered, derived from a count register of width $clog2(DEPTH)+1.
- Reset asserted mid-operation discards all tags. The econV0 instance must share this reset so that no orphan results appear.

## Configuration
- ECON_ARB_STATS_EN defined: adds output `stat_cnt` (NREQ*16 bits).
  - Requester i's counter occupies [i*16 +: 16] and increments on each result handshake to requester i.
  - Counters wrap modulo 2^16 and reset to 0.
- ECON_ARB_STATS_EN undefined: no `stat_cnt` port and no counter logic.

## Structure
- Package econ_arb_pkg holds:
  - IN_W and OUT_W constants
  - tag_t typedef (logic [2:0])
  - the rr_pick function (round-robin search from a pointer)
- One sub-module, econ_tag_fifo: a synchronous FIFO of tag_t with count, full and empty. It contains the tag storage, read/write pointers and count; the top level instantiates it once.

## Test plan
- Single requester: req_vld=4'b0100, core latency 5, all rsp_rdy=1 → one accept, then rsp_vld=4'b0100 five cycles later with rsp_dat equal to the expected 54-bit word; inflight returns 1→0.
- Fairness: all four req_vld held high for 8 accepts → grant order 0,1,2,3,0,1,2,3; results returned in the same tag order.
- Full: core_out_rdy blocked by rsp_rdy=0 with DEPTH=8 → after 8 accepts full=1, req_rdy=0 and inflight=8; raising rsp_rdy resumes accepts.
- Backpressure: rsp_rdy[head]=0 for 3 cycles → core_out_rdy=0 and rsp_dat held stable; rsp_rdy of other requesters is ignored.
- Spurious result: core_out_vld=1 while empty → proto_err=1 and stays 1 until rst falls.
- Reset mid-flight: rst low with inflight=3 → inflight=0, ptr=0 and all ready/valid outputs 0 immediately (asynchronously); with stats enabled, stat_cnt=0.
